// File: rtl/spi_rb_pkg.sv
// Shared encodings for the SPI-to-regbank bridge: commands, reply words,
// FSM states and sticky status flag positions.
package spi_rb_pkg;

    localparam logic [3:0] CMD_READ   = 4'h1;
    localparam logic [3:0] CMD_WRITE  = 4'h2;
    localparam logic [3:0] CMD_STATUS = 4'h3;

    localparam logic [15:0] K_ACK  = 16'h4F4B;
    localparam logic [15:0] K_NACK = 16'h4E4B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_READY,
        ST_WRITE,
        ST_STATUS,
        ST_LOCKED
    } state_e;

    localparam int unsigned STS_BADCMD  = 0;
    localparam int unsigned STS_OVERRUN = 1;
    localparam int unsigned STS_TIMEOUT = 2;
    localparam int unsigned STS_WRAP    = 3;

endpackage

// File: rtl/rb_timeout_cnt.sv
// Read-response watchdog: counts cycles since the read pulse and flags
// expiry once P_TIMEOUT cycles have elapsed without being cleared.
module rb_timeout_cnt #(
    parameter int unsigned P_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(P_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // The pulse cycle itself counts as 0, so the next cycle already reads 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (i_clear) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (i_start) begin
            cnt_q <= CNT_W'(1);
            run_q <= 1'b1;
        end else if (run_q && (cnt_q != CNT_W'(P_TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_expired = run_q && (cnt_q == CNT_W'(P_TIMEOUT));

endmodule

// File: rtl/spi_rb_bridge.sv
// Bridges received SPI words to a register bank: burst read/write by header
// command, a status readout, and sticky error flags; all outputs registered.
module spi_rb_bridge
    import spi_rb_pkg::*;
#(
    parameter int unsigned P_ADDR_W  = 8,
    parameter int unsigned P_DATA_W  = 16,
    parameter int unsigned P_TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_csn,
    input  logic                  i_spi_rx,
    input  logic [P_DATA_W-1:0]   i_spi_data,
    output logic [P_DATA_W-1:0]   o_spi_data,
    output logic                  o_spi_valid_tx,
    output logic [P_ADDR_W-1:0]   o_rb_addr,
    output logic                  o_rb_read,
    input  logic                  i_rb_rvalid,
    input  logic [P_DATA_W-1:0]   i_rb_rdata,
    output logic                  o_rb_write,
    output logic [P_DATA_W-1:0]   o_rb_wdata,
    output logic [P_DATA_W/8-1:0] o_rb_bmask,
    output logic [7:0]            o_status
);

    localparam int unsigned P_CMD_W = P_DATA_W - P_ADDR_W;

    state_e              state_q;
    logic [P_ADDR_W-1:0] rb_addr_q;
    logic                rb_read_q;
    logic                rb_write_q;
    logic [P_DATA_W-1:0] rb_wdata_q;
    logic [P_DATA_W-1:0] spi_data_q;
    logic                spi_vld_q;
    logic [7:0]          status_q;

    logic [P_CMD_W-1:0]  hdr_cmd;
    logic [P_ADDR_W-1:0] hdr_addr;
    logic [P_ADDR_W-1:0] addr_inc_d;
    logic                addr_wrap;
    logic                rd_clear;
    logic                rd_expired;

    assign {hdr_cmd, hdr_addr} = i_spi_data;
    assign addr_inc_d = rb_addr_q + 1'b1;
    assign addr_wrap  = &rb_addr_q;

    // Watchdog only runs while a read is outstanding and nothing ended it.
    assign rd_clear = i_csn | i_rb_rvalid | (state_q != ST_RD_WAIT);

    rb_timeout_cnt #(.P_TIMEOUT(P_TIMEOUT)) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (rb_read_q),
        .i_clear   (rd_clear),
        .o_expired (rd_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rb_addr_q  <= '0;
            rb_read_q  <= 1'b0;
            rb_write_q <= 1'b0;
            rb_wdata_q <= '0;
            spi_data_q <= '0;
            spi_vld_q  <= 1'b0;
            status_q   <= '0;
        end else begin
            rb_read_q  <= 1'b0;
            rb_write_q <= 1'b0;
            spi_vld_q  <= 1'b0;
            if (i_csn) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_spi_rx) begin
                            rb_addr_q <= hdr_addr;
                            if (hdr_cmd == P_CMD_W'(CMD_READ)) begin
                                rb_read_q <= 1'b1;
                                state_q   <= ST_RD_WAIT;
                            end else if (hdr_cmd == P_CMD_W'(CMD_WRITE)) begin
                                state_q <= ST_WRITE;
                            end else if (hdr_cmd == P_CMD_W'(CMD_STATUS)) begin
                                state_q <= ST_STATUS;
                            end else begin
                                status_q[STS_BADCMD] <= 1'b1;
                                state_q              <= ST_LOCKED;
                            end
                        end
                    end
                    ST_RD_WAIT: begin
                        if (i_spi_rx) status_q[STS_OVERRUN] <= 1'b1;
                        if (i_rb_rvalid) begin
                            spi_data_q <= i_rb_rdata;
                            spi_vld_q  <= 1'b1;
                            state_q    <= ST_RD_READY;
                        end else if (rd_expired) begin
                            spi_data_q            <= P_DATA_W'(K_NACK);
                            spi_vld_q             <= 1'b1;
                            status_q[STS_TIMEOUT] <= 1'b1;
                            state_q               <= ST_LOCKED;
                        end
                    end
                    ST_RD_READY: begin
                        if (i_spi_rx) begin
                            rb_addr_q <= addr_inc_d;
                            if (addr_wrap) status_q[STS_WRAP] <= 1'b1;
                            rb_read_q <= 1'b1;
                            state_q   <= ST_RD_WAIT;
                        end
                    end
                    ST_WRITE: begin
                        // ACK/increment of the previous write may coincide with
                        // the next word; that write then lands on the new address.
                        if (rb_write_q) begin
                            spi_data_q <= P_DATA_W'(K_ACK);
                            spi_vld_q  <= 1'b1;
                            rb_addr_q  <= addr_inc_d;
                            if (addr_wrap) status_q[STS_WRAP] <= 1'b1;
                        end
                        if (i_spi_rx) begin
                            rb_write_q <= 1'b1;
                            rb_wdata_q <= i_spi_data;
                        end
                    end
                    ST_STATUS: begin
                        spi_data_q <= P_DATA_W'(status_q);
                        spi_vld_q  <= 1'b1;
                        status_q   <= '0;
                        state_q    <= ST_LOCKED;
                    end
                    ST_LOCKED: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_rb_addr      = rb_addr_q;
    assign o_rb_read      = rb_read_q;
    assign o_rb_write     = rb_write_q;
    assign o_rb_wdata     = rb_wdata_q;
    assign o_rb_bmask     = '0;
    assign o_spi_data     = spi_data_q;
    assign o_spi_valid_tx = spi_vld_q;
    assign o_status       = status_q;

endmodule

// File: doc/spi_rb_bridge.md
SPI_RB_BRIDGE -- requirements
Module: spi_rb_bridge

Interface
REQ-001 P_ADDR_W, 8, regbank address width; P_DATA_W - P_ADDR_W SHALL be >= 4.
REQ-002 P_DATA_W, 16, SPI word and regbank data width.
REQ-003 P_TIMEOUT, 15, maximum cycles to wait for regbank read data (>= 1).
REQ-004 i_clk  in  1  main clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_csn  in  1  SPI chip select, active-low, synchronous to i_clk.
REQ-006 i_spi_rx  in  1  one-cycle pulse: i_spi_data holds a received word.
REQ-007 i_spi_data  in  P_DATA_W  received word; header = {cmd[P_DATA_W-P_ADDR_W], addr[P_ADDR_W]}.
REQ-008 o_spi_data  out  P_DATA_W  word to transmit; o_spi_valid_tx  out  1  one-cycle load strobe.
REQ-009 o_rb_addr  out  P_ADDR_W  regbank address, shared by reads and writes.
REQ-010 o_rb_read  out  1  read request pulse; i_rb_rvalid  in  1  read data valid; i_rb_rdata  in  P_DATA_W.
REQ-011 o_rb_write  out  1  write pulse; o_rb_wdata  out  P_DATA_W; o_rb_bmask  out  P_DATA_W/8  tied 0.
REQ-012 o_status  out  8  sticky error flags {4'b0, wrap, timeout, overrun, badcmd}.

Function
REQ-013 Commands: 0x1 burst READ, 0x2 burst WRITE, 0x3 STATUS; any other value is badcmd.
REQ-014 States: IDLE, RD_WAIT, RD_READY, WRITE, STATUS, LOCKED.
REQ-015 IDLE + header rx: latch addr into o_rb_addr, then go to RD_WAIT (READ, o_rb_read pulsed next cycle), WRITE, STATUS, or LOCKED (badcmd set).
REQ-016 RD_WAIT: on i_rb_rvalid, drive o_spi_data=i_rb_rdata and pulse o_spi_valid_tx in the next cycle, then go to RD_READY.
REQ-017 RD_WAIT: timeout counter starts at 0 on the read pulse; if it reaches P_TIMEOUT without rvalid, load K_NACK=16'h4E4B, set timeout, go to LOCKED.
REQ-018 RD_READY + rx (dummy word): increment address, pulse o_rb_read, go to RD_WAIT.
REQ-019 rx during RD_WAIT sets overrun; the word is dropped; the pending read completes normally.
REQ-020 WRITE + rx: o_rb_write=1 and o_rb_wdata=i_spi_data at the current address, one cycle after rx.
REQ-021 WRITE: after each write, load K_ACK=16'h4F4B with o_spi_valid_tx, then increment the address; the state remains WRITE.
REQ-022 STATUS: load {(P_DATA_W-8)'0, o_status} with o_spi_valid_tx, then clear all flags in the same cycle, then go to LOCKED.
REQ-023 Address increment wraps modulo 2**P_ADDR_W; each wrap sets the wrap flag.
REQ-024 LOCKED ignores rx; it leaves only when i_csn goes high.
REQ-025 i_csn high in any state: next state IDLE; in-flight rb read response is discarded; no write is issued; o_status is kept.
REQ-026 If i_csn rises and rx occurs in the same cycle, i_csn wins and the word is dropped.
REQ-027 At most one of o_rb_read / o_rb_write is high in any cycle; both are single-cycle pulses.
REQ-028 o_spi_valid_tx asserts only while i_csn is low.

Reset
REQ-029 Async reset: state IDLE, o_rb_addr=0, o_rb_read=0, o_rb_write=0, o_rb_wdata=0, o_spi_data=0, o_spi_valid_tx=0, o_status=0, timeout counter 0.
REQ-030 Deassertion of reset is synchronised externally; the block needs no extra reset-release cycle.

Structure
REQ-031 Package spi_rb_pkg SHALL hold the command encodings, K_ACK, K_NACK, the state enum and the status-bit indices.
REQ-032 A sub-module rb_timeout_cnt (parameter P_TIMEOUT; inputs start/clear; output expired) SHALL implement REQ-017.
REQ-033 The implementation SHALL be a single registered FSM plus datapath; o_rb_* and o_spi_* SHALL be driven from flops.

Verification
REQ-034 Header 0x0110, rb returns 0xA5A5 after 2 cycles -> one o_spi_valid_tx with 0xA5A5, o_rb_addr=0x10.
REQ-035 Header 0x02FE, data 0x1111, 0x2222 -> writes 0xFE=0x1111 and 0xFF=0x2222; two ACK 0x4F4B; wrap=1 after the second write.
REQ-036 Header 0x0120, rvalid never asserted -> NACK 0x4E4B after P_TIMEOUT cycles; timeout flag set; further rx ignored.
REQ-037 Header 0x0720, then STATUS frame 0x0300 -> first frame LOCKED; status word 0x0001; flags clear afterwards.
REQ-038 READ burst with rx during RD_WAIT, then i_csn high mid-write frame -> overrun flag set; no rb write issued; state IDLE.
